// File: rtl/anpc3l_leg_sequencer.sv
// -----------------------------------------------------------------------------
// anpc3l_leg_sequencer
// Single-leg 3-level ANPC commutation sequencer. Walks the six leg switches
// along a fixed 7-state chain, one switch toggle per step. A dwell counter
// holds each state for at least (delay + 1) cycles before the next step.
// Fault or disable drops the leg to OFF at once. Leaving OFF always goes
// through the inner zero state Z0.
//
// Ports
//   clk       system clock
//   rst       asynchronous reset, active-high
//   en        leg enable; 0 forces OFF
//   fault     external fault level; sets the fault latch
//   flt_clr   clears the fault latch when fault is low
//   cmd       00 zero, 01 P, 10 N, 11 zero
//   zsel      zero path: 0 upper (Z_U2), 1 lower (Z_L2)
//   td_outer  delay for P<->Z_U1 and Z_L1<->N
//   td_clamp  delay for Z_U1<->Z_U2 and Z_L2<->Z_L1
//   td_inner  delay for Z_U2<->Z0, Z0<->Z_L2 and OFF->Z0
//   gates_o   {S6..S1}, registered, polarity set by GATE_ACTIVE_LOW
//   state_o   current state code
//   busy_o    high while the leg is moving or dwelling
//   flt_o     fault latch
//
// state | meaning
// ------+---------------------------------------------
// P     | positive output, S1 S2 S6 on
// Z_U1  | upper zero, first step (S1 released)
// Z_U2  | upper zero path, clamp S5 on
// Z0    | inner zero state, S5 S6 on
// Z_L2  | lower zero path, clamp S3 on
// Z_L1  | lower zero, S6 released
// N     | negative output, S3 S4 S5 on
// OFF   | all switches off, counter cleared
// -----------------------------------------------------------------------------
module anpc3l_leg_sequencer #(
   parameter int TDELAY_WIDTH    = 8,
   parameter int TD_MIN          = 2,
   parameter bit GATE_ACTIVE_LOW = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    fault,
   input  logic                    flt_clr,
   input  logic [1:0]              cmd,
   input  logic                    zsel,
   input  logic [TDELAY_WIDTH-1:0] td_outer,
   input  logic [TDELAY_WIDTH-1:0] td_clamp,
   input  logic [TDELAY_WIDTH-1:0] td_inner,
   output logic [5:0]              gates_o,
   output logic [2:0]              state_o,
   output logic                    busy_o,
   output logic                    flt_o
);

   typedef enum logic [2:0] {
      P    = 3'd0,
      Z_U1 = 3'd1,
      Z_U2 = 3'd2,
      Z0   = 3'd3,
      Z_L2 = 3'd4,
      Z_L1 = 3'd5,
      N    = 3'd6,
      OFF  = 3'd7
   } state_t;

   localparam logic [TDELAY_WIDTH-1:0] TD_MIN_V = TDELAY_WIDTH'(TD_MIN);

   state_t                  state_q;
   logic [TDELAY_WIDTH-1:0] cnt_q;
   logic                    flt_q;
   logic [5:0]              gates_q;

   state_t                  target;
   state_t                  step_to;
   state_t                  pair_lo;
   logic                    step_up;
   logic [TDELAY_WIDTH-1:0] step_raw;

   function automatic logic [TDELAY_WIDTH-1:0] eff_delay(input logic [TDELAY_WIDTH-1:0] td);
      return (td < TD_MIN_V) ? TD_MIN_V : td;
   endfunction

   function automatic logic [5:0] gate_pattern(input state_t s);
      logic [5:0] g;
      case (s)
         P:       g = 6'b100011;
         Z_U1:    g = 6'b100010;
         Z_U2:    g = 6'b110010;
         Z0:      g = 6'b110000;
         Z_L2:    g = 6'b110100;
         Z_L1:    g = 6'b010100;
         N:       g = 6'b011100;
         default: g = 6'b000000;
      endcase
      return GATE_ACTIVE_LOW ? ~g : g;
   endfunction

   always_comb begin
      case (cmd)
         2'b01:   target = P;
         2'b10:   target = N;
         default: target = zsel ? Z_L2 : Z_U2;
      endcase

      step_up = (target > state_q);
      step_to = step_up ? state_t'(state_q + 3'd1) : state_t'(state_q - 3'd1);
      // The delay of a step belongs to the switch pair it crosses, named by
      // the lower index of the two states.
      pair_lo = step_up ? state_q : step_to;

      case (pair_lo)
         P, Z_L1:    step_raw = td_outer;
         Z_U1, Z_L2: step_raw = td_clamp;
         default:    step_raw = td_inner;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= OFF;
         cnt_q   <= '0;
         flt_q   <= 1'b0;
         gates_q <= gate_pattern(OFF);
      end else begin
         flt_q <= fault | (flt_q & ~flt_clr);

         if (fault || !en || flt_q) begin
            state_q <= OFF;
            cnt_q   <= '0;
            gates_q <= gate_pattern(OFF);
         end else if (state_q == OFF) begin
            state_q <= Z0;
            cnt_q   <= eff_delay(td_inner);
            gates_q <= gate_pattern(Z0);
         end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end else if (state_q != target) begin
            state_q <= step_to;
            cnt_q   <= eff_delay(step_raw);
            gates_q <= gate_pattern(step_to);
         end
      end
   end

   assign gates_o = gates_q;
   assign state_o = state_q;
   assign flt_o   = flt_q;
   assign busy_o  = (state_q != OFF) && ((state_q != target) || (cnt_q != '0));

endmodule
